// File: rtl/irq_ctrl_pkg.sv
// Shared constants and types for the interrupt controller.
// Register offsets, FSM encoding and VEC field layout.
package irq_ctrl_pkg;

  localparam logic [1:0] IRQ_MASK = 2'b00;
  localparam logic [1:0] IRQ_PEND = 2'b01;
  localparam logic [1:0] IRQ_VEC  = 2'b10;
  localparam logic [1:0] IRQ_EOI  = 2'b11;

  localparam int N_IRQ_DEF = 6;
  localparam int VEC_VLD   = 31;
  localparam int ID_W      = 5;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_ASSERT  = 2'd1,
    IRQ_SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder.
// Line 0 has the highest priority.
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int N_IRQ = N_IRQ_DEF
) (
  input  logic [N_IRQ-1:0] req,
  output logic             any,
  output logic [ID_W-1:0]  id
);

  always_comb begin
    any = 1'b0;
    id  = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        any = 1'b1;
        id  = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Programmable interrupt controller with claim / EOI handshake.
// Edge-detected requests, W1C pending, mask, priority winner.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int N_IRQ = N_IRQ_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:2]       addr,
  input  logic             we,
  input  logic             re,
  input  logic [31:0]      din,
  output logic [31:0]      dout,
  input  logic [N_IRQ-1:0] irq_in,
  output logic             intr
);

  logic [N_IRQ-1:0] r_irq_q;
  logic [N_IRQ-1:0] r_mask;
  logic [N_IRQ-1:0] r_pend;
  logic [ID_W-1:0]  r_svc_id;
  irq_state_e       r_state;
  logic             r_intr;

  logic [N_IRQ-1:0] w_rise;
  logic [N_IRQ-1:0] w_act;
  logic [N_IRQ-1:0] w_w1c;
  logic [N_IRQ-1:0] w_clr;
  logic [N_IRQ-1:0] w_pend_nxt;
  logic             w_any;
  logic [ID_W-1:0]  w_win;
  logic             w_wr_mask;
  logic             w_wr_pend;
  logic             w_wr_eoi;
  logic             w_claim;
  irq_state_e       w_state_nxt;
  logic [31:0]      w_mask32;
  logic [31:0]      w_pend32;
  logic [31:0]      w_vec;

  assign w_rise    = irq_in & ~r_irq_q;
  assign w_act     = r_pend & r_mask;
  assign w_wr_mask = we && (addr == IRQ_MASK);
  assign w_wr_pend = we && (addr == IRQ_PEND);
  assign w_wr_eoi  = we && (addr == IRQ_EOI);
  assign w_w1c     = w_wr_pend ? din[N_IRQ-1:0] : '0;

  // A concurrent write wins over the claim read.
  assign w_claim = re && !we && (addr == IRQ_VEC)
                && (r_state == IRQ_ASSERT) && w_any;

  irq_prio_enc #(
    .N_IRQ (N_IRQ)
  ) u_enc (
    .req (w_act),
    .any (w_any),
    .id  (w_win)
  );

  always_comb begin
    w_clr = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      w_clr[i] = w_claim && (w_win == ID_W'(i));
    end
  end

  // New edges take precedence over any clear in the same cycle.
  assign w_pend_nxt = (r_pend & ~w_w1c & ~w_clr) | w_rise;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IRQ_IDLE: begin
        if (w_any) w_state_nxt = IRQ_ASSERT;
      end
      IRQ_ASSERT: begin
        if (!w_any)       w_state_nxt = IRQ_IDLE;
        else if (w_claim) w_state_nxt = IRQ_SERVICE;
      end
      IRQ_SERVICE: begin
        if (w_wr_eoi) w_state_nxt = IRQ_IDLE;
      end
      default: w_state_nxt = IRQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_q  <= '0;
      r_mask   <= '0;
      r_pend   <= '0;
      r_svc_id <= '0;
      r_state  <= IRQ_IDLE;
      r_intr   <= 1'b0;
    end else begin
      r_irq_q <= irq_in;
      r_pend  <= w_pend_nxt;
      r_state <= w_state_nxt;
      r_intr  <= (w_state_nxt == IRQ_ASSERT);
      if (w_wr_mask) r_mask   <= din[N_IRQ-1:0];
      if (w_claim)   r_svc_id <= w_win;
    end
  end

  assign intr = r_intr;

  always_comb begin
    w_mask32 = '0;
    w_pend32 = '0;
    w_vec    = '0;
    w_mask32[N_IRQ-1:0] = r_mask;
    w_pend32[N_IRQ-1:0] = r_pend;
    unique case (r_state)
      IRQ_ASSERT: begin
        w_vec[VEC_VLD]  = 1'b1;
        w_vec[ID_W-1:0] = w_win;
      end
      IRQ_SERVICE: begin
        w_vec[VEC_VLD]  = 1'b1;
        w_vec[ID_W-1:0] = r_svc_id;
      end
      default: w_vec = '0;
    endcase
  end

  always_comb begin
    dout = '0;
    unique case (addr)
      IRQ_MASK: dout = w_mask32;
      IRQ_PEND: dout = w_pend32;
      IRQ_VEC:  dout = w_vec;
      IRQ_EOI:  dout = '0;
      default:  dout = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: vector table plus
// hand-written claim / EOI / reset sequences.
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  localparam int N = 6;

  typedef struct {
    logic        we;
    logic        re;
    logic [1:0]  addr;
    logic [31:0] din;
    logic [N-1:0] irq;
    logic [31:0] exp_dout;
    logic        exp_intr;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:2]   addr = '0;
  logic         we = 1'b0;
  logic         re = 1'b0;
  logic [31:0]  din = '0;
  logic [31:0]  dout;
  logic [N-1:0] irq_in = '0;
  logic         intr;

  int n_cmp = 0;
  int n_err = 0;
  vec_t tbl[$];

  irq_ctrl #(.N_IRQ(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .addr   (addr),
    .we     (we),
    .re     (re),
    .din    (din),
    .dout   (dout),
    .irq_in (irq_in),
    .intr   (intr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic w, input logic r, input logic [1:0] a,
                     input logic [31:0] d, input logic [N-1:0] q,
                     input logic [31:0] ed, input logic ei);
    vec_t v;
    v.we = w; v.re = r; v.addr = a; v.din = d; v.irq = q;
    v.exp_dout = ed; v.exp_intr = ei;
    tbl.push_back(v);
  endtask

  // One cycle: drive at negedge, check pre-edge outputs 1ns later.
  task automatic cyc(input string nm, input logic w, input logic r,
                     input logic [1:0] a, input logic [31:0] d,
                     input logic [N-1:0] q, input logic [31:0] ed,
                     input logic ei);
    @(negedge clk);
    we = w; re = r; addr = a; din = d; irq_in = q;
    #1;
    chk({nm, ".dout"}, dout, ed);
    chk({nm, ".intr"}, {31'b0, intr}, {31'b0, ei});
  endtask

  task automatic chk_all_zero(input string nm);
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      #1;
      chk($sformatf("%s.dout%0d", nm, a), dout, 32'h0);
    end
    chk({nm, ".intr"}, {31'b0, intr}, 32'h0);
  endtask

  initial begin
    // Sequence A: single line 0, claim, EOI
    add(1,0,IRQ_MASK,32'h3F,6'h00,32'h0,0);
    add(0,0,IRQ_MASK,0,6'h01,32'h3F,0);
    add(0,0,IRQ_PEND,0,6'h00,32'h01,0);
    add(0,0,IRQ_VEC ,0,6'h00,32'h8000_0000,1);
    add(0,1,IRQ_VEC ,0,6'h00,32'h8000_0000,1);
    add(0,0,IRQ_VEC ,0,6'h00,32'h8000_0000,0);
    add(1,0,IRQ_EOI ,0,6'h00,32'h0,0);
    add(0,0,IRQ_PEND,0,6'h00,32'h0,0);
    // Sequence B: lines 4 and 1 together
    add(0,0,IRQ_PEND,0,6'h12,32'h0,0);
    add(0,0,IRQ_PEND,0,6'h00,32'h12,0);
    add(0,1,IRQ_VEC ,0,6'h00,32'h8000_0001,1);
    add(0,0,IRQ_PEND,0,6'h00,32'h10,0);
    add(0,0,IRQ_VEC ,0,6'h00,32'h8000_0001,0);
    add(1,0,IRQ_EOI ,0,6'h00,32'h0,0);
    add(0,0,IRQ_VEC ,0,6'h00,32'h0,0);
    add(0,0,IRQ_VEC ,0,6'h00,32'h8000_0004,1);
    add(0,1,IRQ_VEC ,0,6'h00,32'h8000_0004,1);
    add(1,0,IRQ_EOI ,0,6'h00,32'h0,0);
    // Sequence C: masking
    add(1,0,IRQ_MASK,32'h0,6'h00,32'h3F,0);
    add(0,0,IRQ_PEND,0,6'h04,32'h0,0);
    add(0,0,IRQ_PEND,0,6'h00,32'h04,0);
    add(0,0,IRQ_PEND,0,6'h00,32'h04,0);
    add(1,0,IRQ_MASK,32'h04,6'h00,32'h0,0);
    add(0,0,IRQ_MASK,0,6'h00,32'h04,0);
    add(0,0,IRQ_VEC ,0,6'h00,32'h8000_0002,1);
    add(1,0,IRQ_MASK,32'h0,6'h00,32'h04,1);
    add(0,0,IRQ_VEC ,0,6'h00,32'h8000_0000,1);
    add(0,0,IRQ_PEND,0,6'h00,32'h04,0);
    add(0,0,IRQ_VEC ,0,6'h00,32'h0,0);
    // Sequence D: W1C vs rising edge
    add(1,0,IRQ_PEND,32'h08,6'h08,32'h04,0);
    add(1,0,IRQ_PEND,32'h04,6'h00,32'h0C,0);
    add(0,0,IRQ_PEND,0,6'h00,32'h08,0);
    add(1,0,IRQ_PEND,32'hFFFF_FFFF,6'h00,32'h08,0);
    add(0,0,IRQ_PEND,0,6'h00,32'h0,0);

    #1;
    chk_all_zero("rst0");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      cyc($sformatf("v%0d", i), tbl[i].we, tbl[i].re, tbl[i].addr,
          tbl[i].din, tbl[i].irq, tbl[i].exp_dout, tbl[i].exp_intr);
    end

    // Write+read on VEC ignores the claim; arrivals during SERVICE
    cyc("e0",  1,0,IRQ_MASK,32'h21,6'h00,32'h0,0);
    cyc("e1",  0,0,IRQ_PEND,0,6'h01,32'h0,0);
    cyc("e2",  0,0,IRQ_PEND,0,6'h00,32'h01,0);
    cyc("e3",  1,1,IRQ_VEC ,0,6'h00,32'h8000_0000,1);
    cyc("e4",  0,1,IRQ_VEC ,0,6'h00,32'h8000_0000,1);
    cyc("e5",  0,0,IRQ_PEND,0,6'h20,32'h0,0);
    cyc("e6",  0,0,IRQ_PEND,0,6'h00,32'h20,0);
    cyc("e7",  0,0,IRQ_VEC ,0,6'h00,32'h8000_0000,0);
    cyc("e8",  1,0,IRQ_EOI ,0,6'h00,32'h0,0);
    cyc("e9",  0,0,IRQ_VEC ,0,6'h00,32'h0,0);
    cyc("e10", 0,0,IRQ_VEC ,0,6'h00,32'h8000_0005,1);
    cyc("e11", 0,1,IRQ_VEC ,0,6'h00,32'h8000_0005,1);
    cyc("e12", 0,0,IRQ_PEND,0,6'h01,32'h0,0);
    cyc("e13", 0,0,IRQ_PEND,0,6'h01,32'h01,0);
    cyc("e14", 0,0,IRQ_VEC ,0,6'h01,32'h8000_0005,0);

    // Asynchronous reset mid-SERVICE with line 0 held high
    we = 1'b0; re = 1'b0;
    rst_n = 1'b0;
    chk_all_zero("rstA");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    addr = IRQ_PEND;
    #1;
    chk("rstB.pend", dout, 32'h0);
    cyc("r0", 0,0,IRQ_PEND,0,6'h01,32'h01,0);
    cyc("r1", 0,0,IRQ_MASK,0,6'h01,32'h0,0);
    cyc("r2", 0,0,IRQ_VEC ,0,6'h00,32'h0,0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
